axis_separator: RTL
===================

Name: axis_separator

Overview:
- Splits one AXI-Stream input carrying a packed word into two independent AXI-Stream outputs.
- Lower field goes to output 0; upper field goes to output 1.
- Inverse of the two-input joining/combining blocks. Used where a producer emits packed pairs and two consumers drain at different rates.
- Each output has its own 2-entry buffer, so one slow consumer does not stall the other until that buffer fills.

Parameters:
- DATA_WIDTH_0, 16: width of output 0 field, taken from input bits [DATA_WIDTH_0-1:0].
- DATA_WIDTH_1, 8: width of output 1 field, taken from input bits [DATA_WIDTH_0+DATA_WIDTH_1-1:DATA_WIDTH_0].

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- input_valid  in  1  input word valid.
- input_data  in  DATA_WIDTH_0+DATA_WIDTH_1  packed word.
- input_ready  out  1  block accepts the word this cycle.
- output_0_valid  out  1  output 0 field valid.
- output_0_data  out  DATA_WIDTH_0  lower field.
- output_0_ready  in  1  consumer 0 accepts.
- output_1_valid  out  1  output 1 field valid.
- output_1_data  out  DATA_WIDTH_1  upper field.
- output_1_ready  in  1  consumer 1 accepts.

Behaviour:
- Reset (async assert, sync release):
  - both buffers empty, both counts 0, both read/write pointers 0;
  - input_ready=0 while rst is high, and 1 in the first cycle after release;
  - output_0_valid=0, output_1_valid=0.
  - Data registers are not reset; outputs read as don't-care while valid=0.
- Buffers: per output k, a 2-entry FIFO with count_k in 0..2, write pointer wp_k and read pointer rp_k. Each pointer is 1 bit and wraps 1->0.
- input_ready:
  - equals (count_0<2) && (count_1<2), from registered state only;
  - no combinational path from output_k_ready to input_ready.
- Accept: input_valid && input_ready.
  - Writes the lower field into FIFO 0 and the upper field into FIFO 1 in the same cycle.
  - Increments wp_0 and wp_1.
- output_k_valid = (count_k != 0). output_k_data = entry[rp_k], driven from registers.
- Drain k: output_k_valid && output_k_ready. Increments rp_k.
- Count update per k:
  - accept only: +1;
  - drain only: -1;
  - both in the same cycle: unchanged, legal at count 1 and at count 0->... (see below);
  - neither: unchanged.
- Latency: a field accepted at edge N is visible on output_k_valid after edge N. This is 1 cycle; there is no same-cycle bypass.
- Throughput: 1 word/cycle sustained when both consumers hold ready=1.
- Full: when either count reaches 2, input_ready drops the next cycle. A drain of that FIFO restores input_ready one cycle later, since it is registered-derived.
- Asymmetric stall, example (ready_1=0, ready_0=1):
  - output 0 keeps emitting until FIFO 1 holds 2 entries;
  - output 0 can emit at most 2 fields beyond the last field drained from output 1.
- Empty with simultaneous accept: count 0 -> 1. Accept and drain cannot coincide at count 0 because valid=0.
- Ordering: each output preserves input order. Field i on output 0 and field i on output 1 always originate from the same input word.
- AXIS rules:
  - the block never deasserts output_k_valid or changes output_k_data while valid && !ready;
  - input_ready may fall without a handshake.
- Reset mid-stream: all buffered fields are discarded immediately; no partial word survives.

Optional Feature:
- Macro: AXIS_SEPARATOR_LAST_EN.
- With the macro defined:
  - extra ports input_last (in, 1), output_0_last (out, 1), output_1_last (out, 1);
  - input_last is stored alongside both fields in each FIFO entry;
  - output_k_last is presented with its field and obeys the same hold rules as output_k_data;
  - last resets to 0 in all entries.
- Without the macro: these ports and storage do not exist, and the block treats the stream as unframed.

Test Plan:
- Reset: hold rst=1 with input_valid=1 -> input_ready=0, both output valids=0; after release, input_ready=1 next cycle.
- Pass-through, defaults: input_data=24'hA51234 accepted, both readys=1 -> next cycle output_0_data=16'h1234 and output_1_data=8'hA5, each valid for exactly 1 cycle; 8 back-to-back words appear with no bubbles.
- Asymmetric stall: output_1_ready=0, output_0_ready=1, continuous input words 0..7:
  - output 0 emits words 0,1;
  - input_ready=0 after 2 accepts and stays 0;
  - raising output_1_ready yields output 1 words 0,1 in order, and the stream then resumes at word 2.
- Hold stability: output_0_ready=0 for 5 cycles with valid=1 -> output_0_data is unchanged on every one of those cycles.
- Full boundary: both FIFOs at count 2, pulse output_0_ready alone for 1 cycle -> input_ready stays 0 because FIFO 1 is still full. A further pulse of output_1_ready -> input_ready=1 one cycle later.
- Reset mid-stream: assert rst while both FIFOs are full -> valids drop immediately; after release the first output is the first post-reset input word. With AXIS_SEPARATOR_LAST_EN defined, additionally: input_last=1 on word 3 -> output_0_last=1 and output_1_last=1 only on word 3.

Source files
------------

// File: rtl/axis_separator_if.sv
// Bundle of the separator's input stream and its two output streams.
// Optional framing signals exist only when AXIS_SEPARATOR_LAST_EN is defined.
interface axis_separator_if #(
  parameter int DATA_WIDTH_0 = 16,
  parameter int DATA_WIDTH_1 = 8
);
  logic                                 input_valid;
  logic [DATA_WIDTH_0+DATA_WIDTH_1-1:0] input_data;
  logic                                 input_ready;
  logic                                 output_0_valid;
  logic [DATA_WIDTH_0-1:0]              output_0_data;
  logic                                 output_0_ready;
  logic                                 output_1_valid;
  logic [DATA_WIDTH_1-1:0]              output_1_data;
  logic                                 output_1_ready;
`ifdef AXIS_SEPARATOR_LAST_EN
  logic                                 input_last;
  logic                                 output_0_last;
  logic                                 output_1_last;
`endif

  // Separator side: consumes the packed stream, produces the two field streams.
  modport slave (
`ifdef AXIS_SEPARATOR_LAST_EN
    input  input_last,
    output output_0_last,
    output output_1_last,
`endif
    input  input_valid,
    input  input_data,
    output input_ready,
    output output_0_valid,
    output output_0_data,
    input  output_0_ready,
    output output_1_valid,
    output output_1_data,
    input  output_1_ready
  );

  // Environment side: producer of packed words and the two consumers.
  modport master (
`ifdef AXIS_SEPARATOR_LAST_EN
    output input_last,
    input  output_0_last,
    input  output_1_last,
`endif
    output input_valid,
    output input_data,
    input  input_ready,
    input  output_0_valid,
    input  output_0_data,
    output output_0_ready,
    input  output_1_valid,
    input  output_1_data,
    output output_1_ready
  );
endinterface

// File: rtl/axis_separator.sv
// axis_separator: splits one packed AXI-Stream word into two independent
// streams. Lower DATA_WIDTH_0 bits go to output 0, the next DATA_WIDTH_1 bits
// to output 1. Each output owns a 2-entry FIFO so consumers can drain at
// different rates; the input stalls only when either FIFO is full.
// Optional framing: define AXIS_SEPARATOR_LAST_EN to carry input_last through
// both FIFOs alongside each field.

// One output lane: 2-entry FIFO with 1-bit wrapping pointers.
module axis_separator_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
`ifdef AXIS_SEPARATOR_LAST_EN
  input  logic         i_last,
  output logic         o_last,
`endif
  input  logic         i_wr,
  input  logic [W-1:0] i_data,
  input  logic         i_rd_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_rd;

  assign o_valid = (r_cnt != 2'd0);
  assign w_rd    = o_valid && i_rd_ready;
  assign o_data  = r_mem[r_rp];
  assign o_count = r_cnt;

  // Payload storage; not reset since it is only observed while valid.
  // The top never writes while full, so no overflow guard is needed here.
  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wp] <= i_data;
  end

  // Pointers and occupancy; reset discards every buffered field at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_wr) r_wp <= ~r_wp;
      if (w_rd) r_rp <= ~r_rp;
      case ({i_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef AXIS_SEPARATOR_LAST_EN
  logic r_last [2];

  assign o_last = r_last[r_rp];

  // Frame marker per entry; cleared on reset so stale markers never leak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last[0] <= 1'b0;
      r_last[1] <= 1'b0;
    end else if (i_wr) begin
      r_last[r_wp] <= i_last;
    end
  end
`endif
endmodule

module axis_separator #(
  parameter int DATA_WIDTH_0 = 16,
  parameter int DATA_WIDTH_1 = 8
) (
  input  logic             clk,
  input  logic             rst,
  axis_separator_if.slave  bus
);
  logic [1:0] w_cnt_0;
  logic [1:0] w_cnt_1;
  logic       w_in_ready;
  logic       w_accept;

  // Ready comes only from registered occupancy (no path from output readys);
  // held low while reset is asserted.
  assign w_in_ready      = !rst && (w_cnt_0 != 2'd2) && (w_cnt_1 != 2'd2);
  assign bus.input_ready = w_in_ready;
  assign w_accept        = bus.input_valid && w_in_ready;

  axis_separator_fifo #(.W(DATA_WIDTH_0)) u_fifo_0 (
    .clk        (clk),
    .rst        (rst),
`ifdef AXIS_SEPARATOR_LAST_EN
    .i_last     (bus.input_last),
    .o_last     (bus.output_0_last),
`endif
    .i_wr       (w_accept),
    .i_data     (bus.input_data[DATA_WIDTH_0-1:0]),
    .i_rd_ready (bus.output_0_ready),
    .o_valid    (bus.output_0_valid),
    .o_data     (bus.output_0_data),
    .o_count    (w_cnt_0)
  );

  axis_separator_fifo #(.W(DATA_WIDTH_1)) u_fifo_1 (
    .clk        (clk),
    .rst        (rst),
`ifdef AXIS_SEPARATOR_LAST_EN
    .i_last     (bus.input_last),
    .o_last     (bus.output_1_last),
`endif
    .i_wr       (w_accept),
    .i_data     (bus.input_data[DATA_WIDTH_0+DATA_WIDTH_1-1:DATA_WIDTH_0]),
    .i_rd_ready (bus.output_1_ready),
    .o_valid    (bus.output_1_valid),
    .o_data     (bus.output_1_data),
    .o_count    (w_cnt_1)
  );
endmodule
